// File: rtl/eoc_readout_ctrl_if.sv
// Bus between the readout controller, the EOC token chains and the TX FIFO.
// Strobes are qualified by the chain's token and the FIFO full flag in the same cycle.
interface eoc_readout_ctrl_if #(
    parameter int N_CH = 2
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0] eoc_token_i;
    logic [N_CH-1:0] eoc_rqt_data_o;
    logic [N_CH-1:0] eoc_rd_o;
    logic            tx_fifo_full_i;
    logic            tx_fifo_wr_n_o;
    logic [CH_W-1:0] ch_sel_o;

    modport master (
        input  eoc_token_i, tx_fifo_full_i,
        output eoc_rqt_data_o, eoc_rd_o, tx_fifo_wr_n_o, ch_sel_o
    );

    modport slave (
        output eoc_token_i, tx_fifo_full_i,
        input  eoc_rqt_data_o, eoc_rd_o, tx_fifo_wr_n_o, ch_sel_o
    );
endinterface

// File: rtl/eoc_readout_ctrl.sv
// Round-robin EOC readout frame scheduler: request each chain, wait for its token,
// stream up to BURST words into the TX FIFO, stalling while the FIFO is full.
module eoc_readout_ctrl #(
    parameter int N_CH     = 2,
    parameter int BURST    = 16,
    parameter int TOK_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic                 clk40MHz_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 cont_mode_i,
    input  logic                 clr_cnt_i,
    eoc_readout_ctrl_if.master   bus,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic [CNT_W-1:0]     hit_cnt_o,
    output logic [2:0]           state_dbg_o
);
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int WAIT_W = $clog2(TOK_WAIT + 1);
    localparam int BST_W  = $clog2(BURST + 1);
    localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(N_CH - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TOK_WAIT - 1);
    localparam logic [BST_W-1:0]  BURST_LAST = BST_W'(BURST - 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT_TOK, READ, NEXT} state_t;

    state_t            state, state_n;
    logic [CH_W-1:0]   ch, ch_n;
    logic [WAIT_W-1:0] wait_cnt, wait_n;
    logic [BST_W-1:0]  burst_cnt, burst_n;
    logic [N_CH-1:0]   rqt_n;
    logic              tok;
    logic              rd;

    always_ff @(posedge clk40MHz_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            ch        <= '0;
            wait_cnt  <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_n;
            ch        <= ch_n;
            wait_cnt  <= wait_n;
            burst_cnt <= burst_n;
        end
    end

    always_comb begin
        state_n = state;
        ch_n    = ch;
        wait_n  = wait_cnt;
        burst_n = burst_cnt;
        rd      = 1'b0;
        tok     = bus.eoc_token_i[ch];
        case (state)
            IDLE: begin
                if (start_i || cont_mode_i) begin
                    state_n = REQ;
                    ch_n    = '0;
                end
            end
            REQ: begin
                state_n = WAIT_TOK;
                wait_n  = '0;
                burst_n = '0;
            end
            WAIT_TOK: begin
                if (tok) begin
                    state_n = READ;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_n = NEXT;
                end else begin
                    wait_n = wait_cnt + 1'b1;
                end
            end
            READ: begin
                // A full FIFO holds the strobe off but keeps the grant.
                rd = tok && !bus.tx_fifo_full_i;
                if (!tok) begin
                    state_n = NEXT;
                end else if (rd) begin
                    burst_n = burst_cnt + 1'b1;
                    if (burst_cnt == BURST_LAST) begin
                        state_n = NEXT;
                    end
                end
            end
            NEXT: begin
                if (ch != LAST_CH) begin
                    ch_n    = ch + 1'b1;
                    state_n = REQ;
                end else begin
                    ch_n    = '0;
                    state_n = cont_mode_i ? REQ : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Registered outputs are computed from the next state so they line up with it.
    always_comb begin
        rqt_n = '0;
        if (state_n == REQ) begin
            rqt_n = N_CH'(1) << ch_n;
        end
    end

    always_ff @(posedge clk40MHz_i or posedge rst_i) begin
        if (rst_i) begin
            bus.eoc_rqt_data_o <= '0;
            busy_o             <= 1'b0;
            frame_done_o       <= 1'b0;
            hit_cnt_o          <= '0;
        end else begin
            bus.eoc_rqt_data_o <= rqt_n;
            busy_o             <= (state_n != IDLE);
            frame_done_o       <= (state_n == NEXT) && (ch_n == LAST_CH);
            if (clr_cnt_i) begin
                hit_cnt_o <= '0;
            end else if (rd && (hit_cnt_o != {CNT_W{1'b1}})) begin
                hit_cnt_o <= hit_cnt_o + 1'b1;
            end
        end
    end

    assign bus.eoc_rd_o       = rd ? (N_CH'(1) << ch) : '0;
    assign bus.tx_fifo_wr_n_o = !rd;
    assign bus.ch_sel_o       = ch;
    assign state_dbg_o        = state;
endmodule

// File: tb/tb_eoc_readout_ctrl.sv
// Randomized bench: chains are modelled as word counts, each frame's expected
// write sequence is derived from the round-robin/burst rules and checked by a monitor.
`timescale 1ns/1ps
module tb_eoc_readout_ctrl;
    localparam int N_CH     = 3;
    localparam int BURST    = 5;
    localparam int TOK_WAIT = 3;
    localparam int CNT_W    = 6;
    localparam int W        = 5;
    localparam int HIT_MAX  = (1 << CNT_W) - 1;
    localparam logic [W-1:0] MARK = 5'b10000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             cont = 1'b0;
    logic             clr = 1'b0;
    logic             busy, frame_done;
    logic [CNT_W-1:0] hit;
    logic [2:0]       state_dbg;

    eoc_readout_ctrl_if #(.N_CH(N_CH)) bus ();

    eoc_readout_ctrl #(.N_CH(N_CH), .BURST(BURST), .TOK_WAIT(TOK_WAIT), .CNT_W(CNT_W)) dut (
        .clk40MHz_i  (clk),
        .rst_i       (rst),
        .start_i     (start),
        .cont_mode_i (cont),
        .clr_cnt_i   (clr),
        .bus         (bus.master),
        .busy_o      (busy),
        .frame_done_o(frame_done),
        .hit_cnt_o   (hit),
        .state_dbg_o (state_dbg)
    );

    always #12.5 clk = ~clk;

    int              n_checks = 0;
    int              n_fail = 0;
    logic [W-1:0]    exp_q[$];
    int              rem[N_CH];
    logic [N_CH-1:0] rd_sample;
    bit              full_en = 1'b0;
    int              done_cnt = 0;
    int              mdl_hit = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Chain model: a token stays up while the chain still holds words.
    always @(negedge clk) rd_sample = rst ? '0 : bus.eoc_rd_o;

    always @(posedge clk) begin
        #1;
        for (int c = 0; c < N_CH; c++) begin
            if (rd_sample[c] && rem[c] > 0) rem[c]--;
            bus.eoc_token_i[c] = (rem[c] > 0);
        end
        if (full_en) bus.tx_fifo_full_i = ($urandom_range(0, 3) == 0);
    end

    // Monitor: every write strobe and frame end is matched against the queue.
    always @(negedge clk) begin
        if (!rst) begin
            logic [W-1:0] e;
            check("wr_n_vs_rd", int'(bus.tx_fifo_wr_n_o), int'(bus.eoc_rd_o == '0));
            check("rqt_onehot", int'($countones(bus.eoc_rqt_data_o) <= 1), 1);
            if (!bus.tx_fifo_wr_n_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", int'(bus.eoc_rd_o), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_chan", int'({1'b0, bus.ch_sel_o}), int'(e));
                    check("rd_strobe", int'(bus.eoc_rd_o), 1 << e[3:0]);
                end
                mdl_hit = (mdl_hit < HIT_MAX) ? mdl_hit + 1 : HIT_MAX;
            end
            if (frame_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_done_marker", int'(e), int'(MARK));
                end
                done_cnt++;
            end
        end
    end

    task automatic load(input int a, input int b, input int c);
        @(negedge clk); #2;
        rem[0] = a; rem[1] = b; rem[2] = c;
    endtask

    task automatic push_frames(input int frames);
        int r[N_CH];
        int k;
        r = rem;
        for (int f = 0; f < frames; f++) begin
            for (int c = 0; c < N_CH; c++) begin
                k = (r[c] < BURST) ? r[c] : BURST;
                for (int i = 0; i < k; i++) exp_q.push_back(W'(c));
                r[c] -= k;
            end
            exp_q.push_back(MARK);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(posedge clk); #5; n++;
        end
        if (n >= 3000) check({name, "_timeout"}, n, 0);
        repeat (2) @(posedge clk);
        #5;
    endtask

    task automatic wait_write(input string name);
        int n = 0;
        @(negedge clk); #1;
        while (bus.tx_fifo_wr_n_o && n < 500) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 500) check({name, "_no_write"}, n, 0);
    endtask

    task automatic end_checks(input string name);
        check({name, "_hit_cnt"}, int'(hit), mdl_hit);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_busy_idle"}, int'(busy), 0);
    endtask

    task automatic run_phase(input bit cont_m, input int frames, input bit rnd_full);
        int base = done_cnt;
        int n = 0;
        push_frames(frames);
        full_en = rnd_full;
        @(posedge clk); #1; start = 1'b1; cont = cont_m;
        @(posedge clk); #1; start = 1'b0;
        if (cont_m) begin
            while (done_cnt < base + frames - 1 && n < 3000) begin
                @(posedge clk); #1; n++;
            end
            if (n >= 3000) check("cont_frames_timeout", n, 0);
            cont = 1'b0;
        end
        wait_idle("phase");
        full_en = 1'b0;
        bus.tx_fifo_full_i = 1'b0;
        end_checks("phase");
        check("frames_seen", done_cnt - base, frames);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, n;
        bus.eoc_token_i = '0;
        bus.tx_fifo_full_i = 1'b0;
        for (int c = 0; c < N_CH; c++) rem[c] = 0;

        repeat (3) @(negedge clk);
        check("rst_rqt", int'(bus.eoc_rqt_data_o), 0);
        check("rst_rd", int'(bus.eoc_rd_o), 0);
        check("rst_wr_n", int'(bus.tx_fifo_wr_n_o), 1);
        check("rst_ch_sel", int'(bus.ch_sel_o), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_hit", int'(hit), 0);
        rst = 1'b0;

        // Empty frame: request latency, one-cycle request pulse and timeout length.
        load(0, 0, 0);
        exp_q.push_back(MARK);
        pulse_start();
        got = 0;
        n = 0;
        while (n < 200 && got == 0) begin
            @(negedge clk); #1; n++;
            if (n == 1) begin
                check("lat_rqt_ch0", int'(bus.eoc_rqt_data_o), 1);
                check("lat_busy", int'(busy), 1);
                check("lat_ch_sel0", int'(bus.ch_sel_o), 0);
            end
            if (n == 2) check("rqt_one_cycle", int'(bus.eoc_rqt_data_o), 0);
            if (n == TOK_WAIT + 3) begin
                check("rqt_ch1", int'(bus.eoc_rqt_data_o), 2);
                check("ch_sel1", int'(bus.ch_sel_o), 1);
            end
            if (frame_done) got = n;
        end
        check("empty_frame_len", got, N_CH * (TOK_WAIT + 2));
        wait_idle("empty");
        end_checks("empty");

        // Single shot, chain0 with 3 words.
        load(3, 0, 0);
        run_phase(1'b0, 1, 1'b0);

        // Burst limit across continuous frames, start together with cont.
        load(7, 0, 0);
        run_phase(1'b1, 2, 1'b0);

        // FIFO full for 5 cycles in the middle of a read.
        load(4, 2, 0);
        push_frames(1);
        pulse_start();
        wait_write("stall");
        @(posedge clk); #1; bus.tx_fifo_full_i = 1'b1;
        repeat (5) begin
            @(negedge clk); #1;
            check("stall_rd", int'(bus.eoc_rd_o), 0);
            check("stall_wr_n", int'(bus.tx_fifo_wr_n_o), 1);
            check("stall_ch_sel", int'(bus.ch_sel_o), 0);
            check("stall_busy", int'(busy), 1);
        end
        @(posedge clk); #1; bus.tx_fifo_full_i = 1'b0;
        wait_idle("stall");
        end_checks("stall");

        // Reset during READ.
        load(7, 0, 0);
        push_frames(1);
        pulse_start();
        wait_write("reset");
        #1; rst = 1'b1;
        #1;
        check("mid_rst_rd", int'(bus.eoc_rd_o), 0);
        check("mid_rst_wr_n", int'(bus.tx_fifo_wr_n_o), 1);
        check("mid_rst_rqt", int'(bus.eoc_rqt_data_o), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_frame_done", int'(frame_done), 0);
        check("mid_rst_hit", int'(hit), 0);
        check("mid_rst_ch_sel", int'(bus.ch_sel_o), 0);
        exp_q.delete();
        for (int c = 0; c < N_CH; c++) rem[c] = 0;
        mdl_hit = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        load(2, 3, 1);
        run_phase(1'b0, 1, 1'b0);

        // Saturation, then clear on the same cycle as a write.
        load(30, 30, 30);
        run_phase(1'b1, 6, 1'b1);
        check("sat_hit", int'(hit), HIT_MAX);
        load(8, 0, 0);
        push_frames(1);
        pulse_start();
        wait_write("clr");
        #1; clr = 1'b1; mdl_hit = 0;
        @(posedge clk); #1; clr = 1'b0;
        @(negedge clk); #1;
        check("clr_with_write", int'(hit), 0);
        wait_idle("clr");
        end_checks("clr");

        // Randomized frames with random back-pressure.
        repeat (10) begin
            bit cm;
            cm = 1'($urandom_range(0, 1));
            load($urandom_range(0, 2 * BURST + 1), $urandom_range(0, 2 * BURST + 1),
                 $urandom_range(0, 2 * BURST + 1));
            run_phase(cm, cm ? $urandom_range(1, 3) : 1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/eoc_readout_ctrl.md
# eoc_readout_ctrl

Synthesizable, parametrised readout controller for N_CH end-of-column (EOC) token chains. It sits between the EOC chains and the TX FIFO feeding the serializer. It replaces the single-chain, behavioural request/read sequence with a round-robin frame scheduler that supports single-shot and continuous modes, a per-grant burst limit, a token timeout, and FIFO back-pressure stalling.

## Interface
Parameters:
- N_CH, 2, number of EOC token chains (1..16)
- BURST, 16, max words read from one chain per grant (>=1)
- TOK_WAIT, 4, cycles to wait for a token after a request (>=1)
- CNT_W, 16, width of the word counter

Ports:
- clk40MHz_i  in  1  40 MHz clock; single clock domain
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle pulse; starts one frame (all chains once)
- cont_mode_i  in  1  continuous readout; a new frame starts immediately after each frame ends
- clr_cnt_i  in  1  synchronous clear of hit_cnt_o
- eoc_token_i  in  N_CH  per-chain token: chain has data available
- eoc_rqt_data_o  out  N_CH  per-chain data request, one-hot pulse
- eoc_rd_o  out  N_CH  per-chain read strobe, at most one bit set
- tx_fifo_full_i  in  1  TX FIFO full
- tx_fifo_wr_n_o  out  1  TX FIFO write, active low
- ch_sel_o  out  max(1,$clog2(N_CH))  index of the granted chain; drives the data mux
- busy_o  out  1  high in any state other than IDLE
- frame_done_o  out  1  one-cycle pulse at the end of each frame
- hit_cnt_o  out  CNT_W  saturating count of words written to the FIFO

## Operation
- FSM states: IDLE, REQ, WAIT_TOK, READ, NEXT. Channel pointer `ch` starts at 0 each frame.
- IDLE → REQ (ch=0) when start_i or cont_mode_i is high. start_i is ignored when not in IDLE.
- REQ: eoc_rqt_data_o[ch]=1 for exactly one cycle, then WAIT_TOK. Clear the wait and burst counters.
- WAIT_TOK:
  - eoc_token_i[ch]=1 → READ.
  - Token absent for TOK_WAIT consecutive cycles → NEXT.
- READ:
  - Strobe condition rd = eoc_token_i[ch] & ~tx_fifo_full_i. It is combinational (Mealy).
  - eoc_rd_o[ch]=rd, tx_fifo_wr_n_o=~rd, in the same cycle.
  - Each strobe increments the burst counter.
  - tx_fifo_full_i=1: no strobe; stay in READ (stall); the burst counter holds.
  - eoc_token_i[ch]=0 → NEXT.
  - The BURST-th strobe → NEXT, even if the token is still high. The remaining data is served in the next frame.
- NEXT:
  - If ch<N_CH-1: ch+1 → REQ.
  - Else: frame_done_o=1; then REQ with ch=0 if cont_mode_i, else IDLE.
- cont_mode_i dropping mid-frame: the current frame completes, then IDLE.
- hit_cnt_o: +1 per write strobe; saturates at 2^CNT_W-1. clr_cnt_i has priority over the increment.
- ch_sel_o = ch; it is registered and stable throughout REQ/WAIT_TOK/READ.
- Outputs never assert for more than one chain at a time.

## Timing
- Reset values: eoc_rqt_data_o=0, eoc_rd_o=0, tx_fifo_wr_n_o=1, ch_sel_o=0, busy_o=0, frame_done_o=0, hit_cnt_o=0. The FSM goes to IDLE.
- Reset mid-operation: all strobes deassert asynchronously. No partial FIFO write is held over.
- Latency:
  - start_i at edge k → eoc_rqt_data_o[0] high in cycle k+1.
  - The token is sampled from cycle k+2.
  - First possible read is in cycle k+2's successor edge window (READ entered at k+3).
- A chain that never raises its token costs 1+TOK_WAIT+1 cycles.
- Minimum frame with all tokens absent: N_CH·(TOK_WAIT+2) cycles.
- Simultaneous events:
  - Token falls in the same cycle FIFO goes full → NEXT; no strobe.
  - start_i together with cont_mode_i → a single frame start.
- frame_done_o is high during the NEXT cycle of the last channel only.
- Registered outputs: eoc_rqt_data_o, ch_sel_o, busy_o, frame_done_o, hit_cnt_o.
- Combinational outputs: eoc_rd_o, tx_fifo_wr_n_o.

## Test plan
- N_CH=2, single shot. Chain0 token high for 3 words, chain1 none. → 3 rd/wr strobes on ch0, frame_done after ch1 times out (4 cycles), hit_cnt_o=3, then IDLE.
- BURST=16, chain0 holds token for 20 words, cont_mode_i=1. → 16 strobes, move to ch1; next frame 4 strobes on ch0. Total hit_cnt_o=20.
- tx_fifo_full_i high for 5 cycles mid-read. → no strobes during those cycles, state stays READ, resumes with no word lost. Strobe count equals token-high-and-not-full cycles.
- Assert rst_i during READ. → eoc_rd_o=0 and tx_fifo_wr_n_o=1 immediately, all outputs at reset values, start_i after release begins at ch0.
- hit_cnt_o at 2^CNT_W-1 plus further writes. → stays saturated. Pulsing clr_cnt_i with a simultaneous write → 0.
- Drop cont_mode_i while on ch0 of a frame. → ch1 still served, frame_done_o pulses once, busy_o falls the next cycle.
